// File: rtl/sd_spi_slave.sv
// SPI mode-0 slave, MSB first, oversampled on clk_i.
// TX/RX byte buffers and status exposed on the MCU register bus.
module sd_spi_slave #(
  parameter logic [7:0] FILL_BYTE = 8'hFF,
  parameter int         SYNC_STG  = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       mcu_cs_i,
  input  logic       mcu_wr_i,
  input  logic       mcu_rd_i,
  input  logic [7:0] mcu_addr_i8,
  input  logic [7:0] mcu_wrdat_i8,
  output logic [7:0] mcu_rddat_o8,
  output logic       mcu_int_o,
  input  logic       spi_cs_n_i,
  input  logic       spi_sck_i,
  input  logic       spi_sdi_i,
  output logic       spi_sdo_o,
  output logic       spi_sdo_oe_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [SYNC_STG-1:0] cs_sync;
  logic [SYNC_STG-1:0] sck_sync;
  logic [SYNC_STG-1:0] sdi_sync;
  logic                cs_d;
  logic                sck_d;

  // Not reset: a CS_n held low across rst_i must not
  // look like a fresh falling edge afterwards.
  always_ff @(posedge clk_i) begin
    cs_sync  <= {cs_sync[SYNC_STG-2:0], spi_cs_n_i};
    sck_sync <= {sck_sync[SYNC_STG-2:0], spi_sck_i};
    sdi_sync <= {sdi_sync[SYNC_STG-2:0], spi_sdi_i};
    cs_d     <= cs_sync[SYNC_STG-1];
    sck_d    <= sck_sync[SYNC_STG-1];
  end

  logic cs_s, sck_s, sdi_s;
  logic cs_fall, cs_rise, sck_rise, sck_fall;

  assign cs_s     = cs_sync[SYNC_STG-1];
  assign sck_s    = sck_sync[SYNC_STG-1];
  assign sdi_s    = sdi_sync[SYNC_STG-1];
  assign cs_fall  = cs_d & ~cs_s;
  assign cs_rise  = ~cs_d & cs_s;
  assign sck_rise = ~sck_d & sck_s;
  assign sck_fall = sck_d & ~sck_s;

  logic [1:0] state;
  logic [2:0] bitcnt;
  logic [7:0] rxsr;
  logic [7:0] txsr;
  logic [7:0] rxdat;
  logic [7:0] txbuf;
  logic       rxf, txe, ovr, undr, ien;
  logic       busy;

  logic wr_tx, wr_ctrl, rd_rx;

  assign wr_tx   = mcu_cs_i & mcu_wr_i
                 & (mcu_addr_i8 == 8'h00);
  assign wr_ctrl = mcu_cs_i & mcu_wr_i
                 & (mcu_addr_i8 == 8'h03);
  assign rd_rx   = mcu_cs_i & mcu_rd_i
                 & (mcu_addr_i8 == 8'h01);

  assign busy         = (state != IDLE);
  assign spi_sdo_oe_o = busy;
  assign mcu_int_o    = ien & (rxf | ovr | undr);

  // Later assignments win: set events beat MCU clears,
  // and a TXDAT write lands after LOAD has sampled TXE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      bitcnt    <= 3'd0;
      rxsr      <= 8'h00;
      txsr      <= 8'h00;
      spi_sdo_o <= 1'b0;
      rxdat     <= 8'h00;
      txbuf     <= 8'h00;
      rxf       <= 1'b0;
      txe       <= 1'b1;
      ovr       <= 1'b0;
      undr      <= 1'b0;
      ien       <= 1'b0;
    end else begin
      if (rd_rx)
        rxf <= 1'b0;
      if (wr_ctrl) begin
        ien <= mcu_wrdat_i8[0];
        if (mcu_wrdat_i8[7]) begin
          ovr  <= 1'b0;
          undr <= 1'b0;
        end
      end
      unique case (state)
        IDLE: begin
          if (cs_fall)
            state <= LOAD;
        end
        LOAD: begin
          if (cs_rise) begin
            state     <= IDLE;
            bitcnt    <= 3'd0;
            rxsr      <= 8'h00;
            spi_sdo_o <= 1'b0;
          end else begin
            if (!txe) begin
              txsr      <= txbuf;
              txe       <= 1'b1;
              spi_sdo_o <= txbuf[7];
            end else begin
              txsr      <= FILL_BYTE;
              undr      <= 1'b1;
              spi_sdo_o <= FILL_BYTE[7];
            end
            bitcnt <= 3'd0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state     <= IDLE;
            bitcnt    <= 3'd0;
            rxsr      <= 8'h00;
            spi_sdo_o <= 1'b0;
          end else if (sck_rise) begin
            rxsr   <= {rxsr[6:0], sdi_s};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7)
              state <= DONE;
          end else if (sck_fall && bitcnt != 3'd0) begin
            txsr      <= {txsr[6:0], 1'b0};
            spi_sdo_o <= txsr[6];
          end
        end
        DONE: begin
          if (!rxf || rd_rx) begin
            rxdat <= rxsr;
            rxf   <= 1'b1;
          end else begin
            ovr <= 1'b1;
          end
          if (cs_rise) begin
            state     <= IDLE;
            bitcnt    <= 3'd0;
            spi_sdo_o <= 1'b0;
          end else begin
            state <= LOAD;
          end
        end
      endcase
      if (wr_tx) begin
        txbuf <= mcu_wrdat_i8;
        txe   <= 1'b0;
      end
    end
  end

  always_comb begin
    mcu_rddat_o8 = 8'h00;
    case (mcu_addr_i8)
      8'h01:   mcu_rddat_o8 = rxdat;
      8'h02:   mcu_rddat_o8 = {3'b000, undr, busy,
                               ovr, txe, rxf};
      8'h03:   mcu_rddat_o8 = {7'd0, ien};
      default: mcu_rddat_o8 = 8'h00;
    endcase
  end

endmodule
